// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the two upstream request ports and the shared downstream memory port.
// The arbiter takes the slave view; the environment that drives requests and memory takes master.
interface mem_bus_arbiter_if;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
    output i_ready, i_rdata, i_err, d_ready, d_rdata, d_err,
           mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
    input  i_ready, i_rdata, i_err, d_ready, d_rdata, d_err,
           mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single native memory port with a stall watchdog.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic             clock,
  input logic             reset,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q;
  logic        mem_valid_q, mem_instr_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_wstrb_q;

  logic grant_i, grant_d, busy, expire, done;

`ifdef MEM_ARB_RR_EN
  logic last_i_q;

  // On a tie, whoever was not served last wins; reset value means "D went last".
  always_comb begin
    grant_i = bus.i_valid && (!bus.d_valid || !last_i_q);
    grant_d = bus.d_valid && !grant_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_i_q <= 1'b0;
    end else if (state_q == StIdle && (grant_i || grant_d)) begin
      last_i_q <= grant_i;
    end
  end
`else
  always_comb begin
    grant_d = bus.d_valid;
    grant_i = bus.i_valid && !bus.d_valid;
  end
`endif

  always_comb begin
    busy   = (state_q != StIdle);
    expire = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 1);
    // A transaction caught by reset is dropped silently.
    done   = busy && !reset && (bus.mem_ready || expire);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) begin
        cnt_q <= '0;
        if (grant_i || grant_d) begin
          mem_valid_q <= 1'b1;
          mem_instr_q <= grant_i;
          mem_addr_q  <= grant_i ? bus.i_addr : bus.d_addr;
          mem_wdata_q <= grant_i ? 32'h0 : bus.d_wdata;
          mem_wstrb_q <= grant_i ? 4'h0 : bus.d_wstrb;
        end
      end else if (done) begin
        mem_valid_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_i) begin
          state_d = StBusyI;
        end else if (grant_d) begin
          state_d = StBusyD;
        end
      end
      StBusyI, StBusyD: begin
        if (done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.i_ready   = done && (state_q == StBusyI);
    bus.d_ready   = done && (state_q == StBusyD);
    bus.i_err     = bus.i_ready && !bus.mem_ready;
    bus.d_err     = bus.d_ready && !bus.mem_ready;
    bus.i_rdata   = (bus.i_ready && bus.mem_ready) ? bus.mem_rdata : 32'h0;
    bus.d_rdata   = (bus.d_ready && bus.mem_ready) ? bus.mem_rdata : 32'h0;
    bus.mem_valid = mem_valid_q;
    bus.mem_instr = mem_instr_q;
    bus.mem_addr  = mem_addr_q;
    bus.mem_wdata = mem_wdata_q;
    bus.mem_wstrb = mem_wstrb_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic, all compared against a
// transaction-level model of the arbitration and watchdog rules.
module tb_mem_bus_arbiter;

  localparam int unsigned T = 4;

  logic clock;
  logic reset;
  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.TIMEOUT(T)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks;
  int unsigned n_errors;

  // Model: at most one outstanding downstream transaction.
  bit          m_busy;
  bit          m_is_i;
  bit          m_last_i;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  int unsigned m_stalls;
  bit          e_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, obs, req);
    end
  endtask

  // Called shortly after the falling edge once inputs for this cycle are driven.
  task automatic settle();
    bit e_i, e_d, expire;
    #1;
    expire = (T != 0) && (m_stalls + 1 == T);
    e_done = m_busy && !reset && (bus.mem_ready || expire);
    e_i    = e_done && m_is_i;
    e_d    = e_done && !m_is_i;
    check("i_ready", bus.i_ready, e_i);
    check("i_err", bus.i_err, e_i && !bus.mem_ready);
    check("i_rdata", bus.i_rdata, (e_i && bus.mem_ready) ? bus.mem_rdata : 32'h0);
    check("d_ready", bus.d_ready, e_d);
    check("d_err", bus.d_err, e_d && !bus.mem_ready);
    check("d_rdata", bus.d_rdata, (e_d && bus.mem_ready) ? bus.mem_rdata : 32'h0);
    check("mem_valid", bus.mem_valid, m_busy);
    if (m_busy) begin
      check("mem_instr", bus.mem_instr, m_is_i);
      check("mem_addr", bus.mem_addr, m_addr);
      check("mem_wdata", bus.mem_wdata, m_wdata);
      check("mem_wstrb", bus.mem_wstrb, m_wstrb);
    end
  endtask

  task automatic advance();
    bit win_i;
    @(posedge clock);
    if (reset) begin
      m_busy   = 1'b0;
      m_stalls = 0;
      m_last_i = 1'b0;
    end else if (m_busy) begin
      if (e_done) m_busy = 1'b0;
      else m_stalls++;
    end else if (bus.i_valid || bus.d_valid) begin
      if (bus.i_valid && !bus.d_valid) win_i = 1'b1;
      else if (bus.d_valid && !bus.i_valid) win_i = 1'b0;
`ifdef MEM_ARB_RR_EN
      else win_i = !m_last_i;
`else
      else win_i = 1'b0;
`endif
      m_last_i = win_i;
      m_busy   = 1'b1;
      m_is_i   = win_i;
      m_stalls = 0;
      m_addr   = win_i ? bus.i_addr : bus.d_addr;
      m_wdata  = win_i ? 32'h0 : bus.d_wdata;
      m_wstrb  = win_i ? 4'h0 : bus.d_wstrb;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    advance();
    advance();
    reset = 1'b0;
  endtask

  bit exp_seq[4];
  int n_tie;
  bit drop_d;
  bit i_pend, d_pend;

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_busy = 0; m_is_i = 0; m_last_i = 0; m_stalls = 0;
    m_addr = 0; m_wdata = 0; m_wstrb = 0; e_done = 0;
    bus.i_valid = 0; bus.i_addr = 0; bus.d_valid = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.d_wstrb = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
    reset = 1'b1;
    @(negedge clock);
    do_reset();

    // Reset state, with a stray mem_ready that must be ignored while idle.
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    settle();
    check("rst_mem_instr", bus.mem_instr, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_wstrb", bus.mem_wstrb, 4'h0);
    advance();
    bus.mem_ready = 1'b0;

    // Single fetch, minimum round trip.
    bus.i_valid = 1'b1;
    bus.i_addr  = 32'h100;
    settle();
    advance();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    settle();
    check("fetch_mem_valid", bus.mem_valid, 1'b1);
    check("fetch_mem_instr", bus.mem_instr, 1'b1);
    check("fetch_mem_wstrb", bus.mem_wstrb, 4'h0);
    check("fetch_i_ready", bus.i_ready, 1'b1);
    check("fetch_i_rdata", bus.i_rdata, 32'hDEAD_BEEF);
    advance();
    bus.i_valid   = 1'b0;
    bus.mem_ready = 1'b0;
    settle();
    check("fetch_gap", bus.mem_valid, 1'b0);
    advance();

    // Ties from a fresh reset.
    do_reset();
`ifdef MEM_ARB_RR_EN
    exp_seq[0] = 1'b1; exp_seq[1] = 1'b0; exp_seq[2] = 1'b1; exp_seq[3] = 1'b0;
    n_tie = 4; drop_d = 1'b0;
`else
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0; exp_seq[3] = 1'b0;
    n_tie = 2; drop_d = 1'b1;
`endif
    bus.i_valid = 1'b1; bus.i_addr = 32'h300;
    bus.d_valid = 1'b1; bus.d_addr = 32'h200;
    bus.d_wstrb = 4'hF; bus.d_wdata = 32'h1234_5678;
    for (int k = 0; k < n_tie; k++) begin
      settle();
      advance();
      bus.mem_ready = 1'b1;
      bus.mem_rdata = $urandom;
      settle();
      check("tie_order", bus.mem_instr, exp_seq[k]);
      advance();
      bus.mem_ready = 1'b0;
      if (drop_d && !exp_seq[k]) bus.d_valid = 1'b0;
    end
    bus.i_valid = 1'b0;
    bus.d_valid = 1'b0;
    settle();
    advance();

    // Stall until the watchdog aborts a data read.
    bus.d_valid = 1'b1; bus.d_addr = 32'h400; bus.d_wstrb = 4'h0; bus.d_wdata = 32'h0;
    bus.mem_rdata = 32'hA5A5_A5A5;
    settle();
    advance();
    for (int s = 1; s < T; s++) begin
      settle();
      check("stall_wait", bus.d_ready, 1'b0);
      advance();
    end
    settle();
    check("abort_d_ready", bus.d_ready, 1'b1);
    check("abort_d_err", bus.d_err, 1'b1);
    check("abort_d_rdata", bus.d_rdata, 32'h0);
    advance();
    bus.d_valid = 1'b0;
    settle();
    check("abort_mem_valid", bus.mem_valid, 1'b0);
    advance();

    // mem_ready arrives in the same cycle the watchdog expires.
    bus.d_valid = 1'b1; bus.d_addr = 32'h500; bus.d_wstrb = 4'h3; bus.d_wdata = 32'h0BAD_F00D;
    settle();
    advance();
    for (int s = 1; s < T; s++) begin
      settle();
      advance();
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    settle();
    check("race_d_ready", bus.d_ready, 1'b1);
    check("race_d_err", bus.d_err, 1'b0);
    check("race_d_rdata", bus.d_rdata, 32'hCAFE_F00D);
    advance();
    bus.mem_ready = 1'b0;
    bus.d_valid   = 1'b0;
    settle();
    advance();

    // Reset while a fetch is outstanding.
    bus.i_valid = 1'b1; bus.i_addr = 32'h700;
    settle();
    advance();
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    settle();
    check("rst_no_i_ready", bus.i_ready, 1'b0);
    advance();
    reset = 1'b0;
    bus.i_valid = 1'b0;
    bus.mem_ready = 1'b0;
    settle();
    check("rst_mem_valid", bus.mem_valid, 1'b0);
    advance();
    bus.i_valid = 1'b1; bus.i_addr = 32'h800;
    settle();
    advance();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1122_3344;
    settle();
    check("post_rst_addr", bus.mem_addr, 32'h800);
    check("post_rst_i_ready", bus.i_ready, 1'b1);
    advance();
    bus.i_valid = 1'b0;
    bus.mem_ready = 1'b0;

    // Random traffic; requesters hold payload until served, occasionally drop valid once granted.
    i_pend = 1'b0;
    d_pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!i_pend && $urandom_range(1, 0) == 1) begin
        i_pend = 1'b1;
        bus.i_addr = $urandom;
      end
      if (!d_pend && $urandom_range(1, 0) == 1) begin
        d_pend = 1'b1;
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
        bus.d_wstrb = ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'h0;
      end
      bus.i_valid = i_pend && !(m_busy && m_is_i && $urandom_range(7, 0) == 0);
      bus.d_valid = d_pend && !(m_busy && !m_is_i && $urandom_range(7, 0) == 0);
      bus.mem_ready = ($urandom_range(2, 0) == 0);
      bus.mem_rdata = $urandom;
      reset = ($urandom_range(199, 0) == 0);
      settle();
      if (e_done) begin
        if (m_is_i) i_pend = 1'b0;
        else d_pend = 1'b0;
      end
      advance();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the core's single native memory port between an instruction-fetch requester and a data load/store requester. Upstream it presents two independent valid/ready request ports. Downstream it drives one `mem_valid`/`mem_instr`/`mem_addr`/`mem_wdata`/`mem_wstrb` port and receives `mem_ready`/`mem_rdata`. A watchdog aborts downstream transactions that stall too long, so formal and simulation benches cannot hang on an unresponsive memory model.

## Interface
- `TIMEOUT`, default 255: number of consecutive stalled cycles (`mem_valid`=1, `mem_ready`=0) before abort; 0 disables the watchdog.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `i_valid`  in  1  instruction fetch request.
- `i_addr`  in  32  fetch address.
- `i_ready`  out  1  fetch completion pulse.
- `i_rdata`  out  32  fetch data, valid while `i_ready`=1.
- `i_err`  out  1  fetch aborted by watchdog, valid while `i_ready`=1.
- `d_valid`  in  1  data request.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  store data.
- `d_wstrb`  in  4  byte strobes; 0 means read.
- `d_ready`  out  1  data completion pulse.
- `d_rdata`  out  32  load data, valid while `d_ready`=1.
- `d_err`  out  1  data access aborted, valid while `d_ready`=1.
- `mem_valid`  out  1  downstream request.
- `mem_instr`  out  1  1 = current request is an instruction fetch.
- `mem_addr`  out  32  downstream address.
- `mem_wdata`  out  32  downstream write data.
- `mem_wstrb`  out  4  downstream strobes.
- `mem_ready`  in  1  downstream completion.
- `mem_rdata`  in  32  downstream read data.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- **IDLE:** if any `*_valid`=1, pick a winner and go to BUSY_I or BUSY_D.
  - Register the winner's payload into the `mem_*` outputs.
  - Set `mem_valid`=1 and `mem_instr`=(winner is I).
  - For a fetch, `mem_wstrb`=0 and `mem_wdata`=0.
- **Arbitration, default:** fixed priority, data beats instruction.
- **BUSY_x:** `mem_valid` and the payload are held stable until completion.
  - Completion is `mem_ready`=1.
  - In that cycle the granted `x_ready`=1 and `x_rdata`=`mem_rdata`, combinationally.
  - Next state is IDLE, with `mem_valid`=0.
- **Idle-cycle gating:** `x_rdata` is 0 and `x_err` is 0 whenever `x_ready`=0.
- **Watchdog counter:**
  - Clears on entry to BUSY.
  - Increments each BUSY cycle with `mem_ready`=0.
  - When count = `TIMEOUT`-1 and `mem_ready`=0: in that cycle `x_ready`=1, `x_err`=1, `x_rdata`=0; next state is IDLE; `mem_valid` drops.
- **Simultaneous `mem_ready` and timeout:** normal completion wins, `x_err`=0.
- **Requester protocol:** a requester holds valid and payload until its ready.
  - A requester that drops valid mid-transaction does not cancel it.
  - The latched request completes, and the ready pulse is still issued.
- **The non-granted requester:** sees `ready`=0 throughout and waits.
- **`mem_ready` while IDLE:** ignored.
- **Reset values:** state IDLE, counter 0, all `mem_*` outputs 0, all `*_ready`/`*_err`/`*_rdata` outputs 0.
- **Reset mid-transaction:** the transaction is dropped with no ready or err pulse. `mem_valid`=0 in the cycle after reset is sampled.

## Timing
- Arbitration latency: `x_valid` sampled at cycle N drives `mem_valid`=1 at N+1.
- Minimum completion: `mem_ready`=1 at N+1 gives `x_ready`=1 at N+1, a 2-cycle round trip.
- Back-to-back: at least one IDLE cycle between transactions (`mem_valid` low for ≥1 cycle).
- Abort timing: with `TIMEOUT`=T, `x_ready`+`x_err` fire in the T-th stalled BUSY cycle.
- Outputs `mem_*` are registered. `x_ready`, `x_rdata` and `x_err` are combinational from state and `mem_ready`/`mem_rdata`.

## Configuration
- Macro `MEM_ARB_RR_EN`.
- **Defined:** round-robin arbitration.
  - A `last_grant` flop is updated on every grant; it resets to D.
  - On a tie, the requester not granted last wins, so the first tie after reset grants I.
  - A single requester is always granted immediately.
- **Undefined:** fixed data-over-instruction priority, and no `last_grant` flop exists.

## Test plan
- Single fetch: `i_valid`=1, `i_addr`=0x100 at N, `mem_ready`=1 at N+1 with `mem_rdata`=0xDEADBEEF.
  - Required: `mem_valid`=1, `mem_instr`=1, `mem_wstrb`=0 at N+1.
  - Required: `i_ready`=1, `i_rdata`=0xDEADBEEF at N+1; `mem_valid`=0 at N+2.
- Tie: `i_valid`=`d_valid`=1 at N with `d_addr`=0x200, `d_wstrb`=0xF, `d_wdata`=0x12345678.
  - Required: data served first, I served in the following transaction.
  - With `MEM_ARB_RR_EN`, on repeated ties: I first after reset, then strict alternation I, D, I, D.
- Stall: `mem_ready` held 0 with `TIMEOUT`=4.
  - Required: `d_ready`=1, `d_err`=1, `d_rdata`=0 in the 4th BUSY cycle; `mem_valid`=0 next cycle.
- Timeout race: `mem_ready`=1 in the same cycle the watchdog expires.
  - Required: `d_ready`=1, `d_err`=0, rdata passes through.
- Mid-transaction reset: `reset`=1 during BUSY_I.
  - Required: no `i_ready` pulse and `mem_valid`=0 next cycle.
  - A fresh `i_valid` after reset is granted normally.
